// File: rtl/apb_pkg.sv
// Shared APB types and defaults for the wait-state completer and its memory.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_SLV  = 1'b1;

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between the team's master (requester) and a completer.
interface apb_wait_slave_if #(
    parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_W,
    parameter int DATA_WIDTH = apb_pkg::APB_DATA_W
);
    // Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
    // access cycles (PSEL=1, PENABLE=1); it completes on the edge ending the
    // single access cycle in which PREADY=1. PRDATA/PSLVERR matter only then.
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// Register storage with one valid bit per location; only valid bits are reset.
module apb_slave_mem #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with fixed wait states, a validated register memory and
// PSLVERR for out-of-range addresses or reads of never-written locations.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_wait_slave_if.slave   apb,
    output apb_state_e        dbg_state_o
);

    localparam int                IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  setup;
    logic                  in_access;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  eff_write;
    logic                  oor;
    logic                  err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    apb_slave_mem #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .we_i     (mem_we),
        .waddr_i  (addr_q[IDX_W-1:0]),
        .wdata_i  (wdata_q),
        .raddr_i  (eff_addr[IDX_W-1:0]),
        .rdata_o  (rd_data),
        .rvalid_o (rd_valid)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= ERR_NONE;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_L;
                    addr_d  = apb.PADDR;
                    write_d = apb.PWRITE;
                    wdata_d = apb.PWDATA;
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (apb.PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The response is registered, so it is computed one edge early: from the
    // live bus during setup (zero wait states) or from the captured request.
    always_comb begin
        setup     = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
        in_access = (state_q == ACCESS) && apb.PSEL && apb.PENABLE;
        eff_addr  = setup ? apb.PADDR  : addr_q;
        eff_write = setup ? apb.PWRITE : write_q;
        oor       = {1'b0, eff_addr} >= DEPTH_L;
        err       = oor || (!eff_write && !rd_valid);
        pready_d  = 1'b0;
        pslverr_d = ERR_NONE;
        prdata_d  = '0;
        if (setup ? (WAIT_CYCLES == 0) : (in_access && cnt_q == 4'd1)) begin
            pready_d  = 1'b1;
            pslverr_d = err ? ERR_SLV : ERR_NONE;
            prdata_d  = (!eff_write && !err) ? rd_data : '0;
        end
        mem_we = in_access && (cnt_q == 4'd0) && write_q && !oor;
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed/random APB transfers against a 2-wait-state and a 0-wait-state completer.
module tb_apb_wait_slave;
  import apb_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_wait_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if2 ();
  apb_wait_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
  apb_state_e st2, st0;

  apb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(if2.slave), .dbg_state_o(st2));
  apb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(if0.slave), .dbg_state_o(st0));

  // master-side drive, routed to one target at a time
  logic       m_sel, m_en, m_wr;
  logic [7:0] m_addr, m_wdata;
  logic       tgt0;

  assign if2.PSEL    = m_sel & ~tgt0;
  assign if2.PENABLE = m_en;
  assign if2.PWRITE  = m_wr;
  assign if2.PADDR   = m_addr;
  assign if2.PWDATA  = m_wdata;
  assign if0.PSEL    = m_sel & tgt0;
  assign if0.PENABLE = m_en;
  assign if0.PWRITE  = m_wr;
  assign if0.PADDR   = m_addr;
  assign if0.PWDATA  = m_wdata;

  wire       s_rdy   = tgt0 ? if0.PREADY  : if2.PREADY;
  wire       s_err   = tgt0 ? if0.PSLVERR : if2.PSLVERR;
  wire [7:0] s_rdata = tgt0 ? if0.PRDATA  : if2.PRDATA;

  // scoreboard
  logic [8:0] exp_q[$];
  logic [7:0] mdl_mem [64];
  bit         mdl_val [64];
  int checks = 0;
  int passes = 0;
  int n_done2 = 0;
  int n_pready2 = 0;

  always @(posedge PCLK) if (if2.PREADY === 1'b1) n_pready2 <= n_pready2 + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mdl_val[i] = 1'b0;
  endtask

  task automatic do_reset();
    m_sel = 1'b0;
    m_en  = 1'b0;
    PRESET = 1'b1;
    #1;
    check("reset_pready", 16'(s_rdy), 16'h0);
    @(negedge PCLK);
    check("reset_state2", 16'(st2), 16'(IDLE));
    PRESET = 1'b0;
    clear_model();
  endtask

  // Starts at a negedge with the setup cycle; returns at the negedge of the
  // cycle after PREADY (or after an abort) with PSEL low.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data, input int abort_at);
    logic [8:0] exp;
    bit err;
    int lat;
    int cyc;
    err = (addr >= 8'd64) || (!wr && !mdl_val[addr[5:0]]);
    exp = {err, (!wr && !err) ? mdl_mem[addr[5:0]] : 8'h00};
    exp_q.push_back(exp);
    lat = tgt0 ? 1 : 3;
    m_sel = 1'b1; m_en = 1'b0; m_wr = wr; m_addr = addr; m_wdata = data;
    @(negedge PCLK);
    m_en = 1'b1;
    m_addr = 8'($urandom);
    m_wdata = 8'($urandom);
    m_wr = ~wr;
    cyc = 1;
    while (s_rdy !== 1'b1 && cyc <= 20) begin
      if (cyc == abort_at) begin
        m_sel = 1'b0;
        m_en  = 1'b0;
        void'(exp_q.pop_front());
        repeat (2) begin
          @(negedge PCLK);
          check("abort_no_pready", 16'(s_rdy), 16'h0);
        end
        return;
      end
      @(negedge PCLK);
      cyc++;
    end
    if (cyc > 20) begin
      check("pready_timeout", 16'(s_rdy), 16'h1);
      void'(exp_q.pop_front());
      m_sel = 1'b0; m_en = 1'b0;
      return;
    end
    check("latency", 16'(cyc), 16'(lat));
    check("response", 16'({s_err, s_rdata}), 16'(exp_q.pop_front()));
    if (wr && !err) begin
      mdl_mem[addr[5:0]] = data;
      mdl_val[addr[5:0]] = 1'b1;
    end
    if (!tgt0) n_done2++;
    @(negedge PCLK);
    m_sel = 1'b0;
    m_en  = 1'b0;
    check("post_ready_zero", 16'({s_rdy, s_err, s_rdata}), 16'h0);
  endtask

  initial begin
    tgt0 = 1'b0;
    m_sel = 1'b0; m_en = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    PRESET = 1'b1;
    clear_model();
    repeat (2) @(negedge PCLK);
    check("reset_outputs2", 16'({if2.PREADY, if2.PSLVERR, if2.PRDATA}), 16'h0);
    check("reset_outputs0", 16'({if0.PREADY, if0.PSLVERR, if0.PRDATA}), 16'h0);
    check("reset_state0", 16'(st0), 16'(IDLE));
    PRESET = 1'b0;
    @(negedge PCLK);

    xfer(1'b0, 8'h05, 8'h00, 0);
    xfer(1'b1, 8'h03, 8'h77, 2);
    xfer(1'b0, 8'h03, 8'h00, 0);
    xfer(1'b1, 8'h16, 8'h23, 0);
    xfer(1'b0, 8'h16, 8'h00, 0);

    for (int i = 0; i < 8; i++) xfer(1'b1, 8'(i), 8'(2 * i), 0);
    for (int i = 0; i < 8; i++) xfer(1'b0, 8'(i), 8'h00, 0);

    xfer(1'b1, 8'h40, 8'h55, 0);
    xfer(1'b0, 8'h40, 8'h00, 0);

    // PSEL+PENABLE while idle must be ignored
    m_sel = 1'b1; m_en = 1'b1; m_addr = 8'h16;
    repeat (2) begin
      @(negedge PCLK);
      check("proto_err_state", 16'(st2), 16'(IDLE));
      check("proto_err_pready", 16'(s_rdy), 16'h0);
    end
    m_sel = 1'b0; m_en = 1'b0;
    @(negedge PCLK);

    xfer(1'b1, 8'h16, 8'hA5, 0);
    xfer(1'b0, 8'h16, 8'h00, 0);

    for (int i = 0; i < 8; i++)
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 71)), 8'($urandom_range(0, 255)), 0);

    xfer(1'b1, 8'h02, 8'h11, 0);
    do_reset();
    xfer(1'b0, 8'h02, 8'h00, 0);
    check("pready_count2", 16'(n_pready2), 16'(n_done2));

    tgt0 = 1'b1;
    xfer(1'b1, 8'h09, 8'h3C, 0);
    xfer(1'b0, 8'h09, 8'h00, 0);
    xfer(1'b0, 8'h02, 8'h00, 0);
    xfer(1'b1, 8'h41, 8'h99, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
